// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer. Each accepted word is routed by sel into one of
// two independent 2-entry FIFOs, and each FIFO keeps its own count of accepted words.
module demux2_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   input  logic             sel,
   output logic [WIDTH-1:0] z0,
   output logic             z0_valid,
   input  logic             z0_ready,
   output logic [WIDTH-1:0] z1,
   output logic             z1_valid,
   input  logic             z1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   logic [1:0] full;
   logic [1:0] zr;
   logic       acc;

   // d_ready looks only at the occupancy of the selected FIFO. A pop in the
   // same cycle does not free space for the input.
   assign zr      = {z1_ready, z0_ready};
   assign d_ready = ~full[sel];
   assign acc     = d_valid && d_ready;

   for (genvar g = 0; g < 2; g++) begin : g_fifo
      occ_t             state_q, state_d;
      logic [WIDTH-1:0] head_q, tail_q;
      logic [CNT_W-1:0] cnt_q;
      logic             push, pop, valid, full_l;

      assign push = acc && (sel == (g == 1));
      assign pop  = valid && zr[g];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) state_q <= EMPTY;
         else     state_q <= state_d;
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE:     if (push && !pop) state_d = TWO;
                     else if (pop && !push) state_d = EMPTY;
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end

      always_comb begin
         valid  = (state_q != EMPTY);
         full_l = (state_q == TWO);
      end

      // head_q drives the output. tail_q holds the second word only while the FIFO is in TWO.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            head_q <= '0;
            tail_q <= '0;
         end else begin
            case (state_q)
               EMPTY: if (push) head_q <= d;
               ONE: begin
                  if (push && pop) head_q <= d;
                  else if (push)   tail_q <= d;
               end
               TWO:     if (pop) head_q <= tail_q;
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)       cnt_q <= '0;
         else if (push) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign full     = {g_fifo[1].full_l, g_fifo[0].full_l};
   assign z0       = g_fifo[0].head_q;
   assign z0_valid = g_fifo[0].valid;
   assign cnt0     = g_fifo[0].cnt_q;
   assign z1       = g_fifo[1].head_q;
   assign z1_valid = g_fifo[1].valid;
   assign cnt1     = g_fifo[1].cnt_q;

endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream with 2-bit counters, so that counter wrap
// is reached in a handful of accepted words.
module tb_demux2_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] d;
   logic             d_valid, d_ready, sel;
   logic [WIDTH-1:0] z0, z1;
   logic             z0_valid, z0_ready, z1_valid, z1_ready;
   logic [CNT_W-1:0] cnt0, cnt1;

   int nvec = 0;
   int nerr = 0;

   demux2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready), .sel(sel),
      .z0(z0), .z0_valid(z0_valid), .z0_ready(z0_ready),
      .z1(z1), .z1_valid(z1_valid), .z1_ready(z1_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; d = '0; d_valid = 1'b0; sel = 1'b0; z0_ready = 1'b0; z1_ready = 1'b0;

      // reset held for 3 cycles, then idle
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_z0_valid", z0_valid, 0);
      chk("rst_z1_valid", z1_valid, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
      chk("rst_z0", z0, 0);
      chk("rst_z1", z1, 0);
      sel = 1'b0; #1;
      chk("rst_ready_sel0", d_ready, 1);
      sel = 1'b1; #1;
      chk("rst_ready_sel1", d_ready, 1);

      // basic routing, both consumers ready
      z0_ready = 1'b1; z1_ready = 1'b1;
      d = 8'hA5; sel = 1'b0; d_valid = 1'b1; #1;
      chk("route_ready_a5", d_ready, 1);
      chk("route_no_comb_path", z0_valid, 0);
      tick();
      d = 8'h3C; sel = 1'b1;
      chk("route_z0_valid", z0_valid, 1);
      chk("route_z0", z0, 8'hA5);
      chk("route_cnt0", cnt0, 1);
      chk("route_z1_empty", z1_valid, 0);
      tick();
      d_valid = 1'b0;
      chk("route_z1_valid", z1_valid, 1);
      chk("route_z1", z1, 8'h3C);
      chk("route_cnt1", cnt1, 1);
      chk("route_z0_drained", z0_valid, 0);
      tick();
      chk("route_z1_drained", z1_valid, 0);

      // FIFO 0 fills under backpressure
      do_reset();
      z0_ready = 1'b0; z1_ready = 1'b0;
      d_valid = 1'b1; sel = 1'b0; d = 8'h01;
      tick();
      d = 8'h02; #1;
      chk("bp_ready_second", d_ready, 1);
      tick();
      d = 8'h03; #1;
      chk("bp_ready_third", d_ready, 0);
      chk("bp_cnt0", cnt0, 2);
      chk("bp_z0_head", z0, 8'h01);
      tick();
      chk("bp_cnt0_held", cnt0, 2);
      chk("bp_z0_held", z0, 8'h01);

      // with FIFO 0 full, FIFO 1 still accepts words
      sel = 1'b1; d = 8'h55; #1;
      chk("ind_ready_sel1", d_ready, 1);
      tick();
      chk("ind_z1_valid", z1_valid, 1);
      chk("ind_z1", z1, 8'h55);
      chk("ind_cnt1", cnt1, 1);
      chk("ind_z0_valid", z0_valid, 1);
      chk("ind_z0_stable", z0, 8'h01);
      chk("ind_cnt0", cnt0, 2);

      // one pop from FIFO 0, then the held third word is accepted
      sel = 1'b0; d = 8'h03; z0_ready = 1'b1; #1;
      chk("bp_ready_during_pop", d_ready, 0);
      tick();
      z0_ready = 1'b0; #1;
      chk("bp_z0_second", z0, 8'h02);
      chk("bp_ready_after_pop", d_ready, 1);
      chk("bp_cnt0_no_accept", cnt0, 2);
      tick();
      d_valid = 1'b0;
      chk("bp_cnt0_third", cnt0, 3);
      chk("bp_z0_after_third", z0, 8'h02);
      sel = 1'b0; #1;
      chk("bp_full_again", d_ready, 0);

      // push and pop together while FIFO 1 holds one word
      do_reset();
      z0_ready = 1'b0; z1_ready = 1'b0;
      d_valid = 1'b1; sel = 1'b1; d = 8'h10;
      tick();
      chk("pp_z1_10", z1, 8'h10);
      z1_ready = 1'b1; d = 8'h20; #1;
      chk("pp_ready", d_ready, 1);
      tick();
      chk("pp_z1_20", z1, 8'h20);
      chk("pp_ready_one", d_ready, 1);
      d = 8'h30;
      tick();
      chk("pp_z1_30", z1, 8'h30);
      d = 8'h40;
      tick();
      chk("pp_z1_40", z1, 8'h40);
      chk("pp_cnt1_wrap", cnt1, 0);
      chk("pp_z1_valid", z1_valid, 1);
      d_valid = 1'b0;
      tick();
      chk("pp_drained", z1_valid, 0);

      // counter wrap, then reset in the middle of a cycle
      do_reset();
      z0_ready = 1'b1; z1_ready = 1'b0; d_valid = 1'b1; sel = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         d = WIDTH'(i);
         tick();
      end
      d_valid = 1'b0; z0_ready = 1'b0;
      chk("wrap_cnt0", cnt0, 1);
      chk("wrap_z0", z0, 8'h05);
      chk("wrap_z0_valid", z0_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_z0_valid", z0_valid, 0);
      chk("arst_cnt0", cnt0, 0);
      chk("arst_z0", z0, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("arst_release_z0_valid", z0_valid, 0);
      chk("arst_release_z1_valid", z1_valid, 0);
      chk("arst_release_cnt0", cnt0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
